// File: rtl/apb_ucpd_tx_fsm.sv
// apb_ucpd_tx_fsm: UCPD transmit sequencer producing field enables, completion strobes and TX handshakes.
module apb_ucpd_tx_fsm #(
    parameter int IFRGAP_BITS = 25,
    parameter int CNT_W       = 10
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             bit_clk_red,
    input  logic             transmit_en,
    input  logic             tx_hrst,
    input  logic [1:0]       tx_mode,
    input  logic [CNT_W-1:0] tx_paysize,
    input  logic             rx_busy,
    output logic             pre_en,
    output logic             sop_en,
    output logic             data_en,
    output logic             crc_en,
    output logic             eop_en,
    output logic             tx_pre_cmplt,
    output logic             tx_sop_cmplt,
    output logic             tx_data_cmplt,
    output logic             tx_crc_cmplt,
    output logic             tx_eop_cmplt,
    output logic             tx_wait_cmplt,
    output logic             tx_bit5_cmplt,
    output logic             txfifo_ld_en,
    output logic             txdr_req,
    output logic             crc_init,
    output logic             crc_byte_vld,
    output logic             tx_msg_disc,
    output logic             tx_hrst_disc
);
    typedef enum logic [2:0] {IDLE, PRE, SOP, DATA, CRC, EOP, WAIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       bcnt_q, bcnt_d, last_bit;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, pay_m1, byte_nxt;
    logic             hrst_seq_q, hrst_seq_d, crst_seq_q, crst_seq_d, hrst_pend_q, hrst_pend_d;
    logic             transmit_en_q, tx_hrst_q, crst_lvl_q;
    logic             xmit_red_q, xmit_red_d, hrst_red_q, hrst_red_d, crst_red_q, crst_red_d;
    logic             txdr_req_q, txdr_req_d;
    logic             done, msg, abort, crst_lvl;

    assign crst_lvl   = tx_mode == 2'b01;
    assign xmit_red_d = transmit_en & ~transmit_en_q;
    assign hrst_red_d = tx_hrst & ~tx_hrst_q;
    assign crst_red_d = crst_lvl & ~crst_lvl_q;

    assign pre_en   = state_q == PRE;
    assign sop_en   = state_q == SOP;
    assign data_en  = state_q == DATA;
    assign crc_en   = state_q == CRC;
    assign eop_en   = state_q == EOP;
    assign txdr_req = txdr_req_q;

    assign last_bit = (state_q == PRE)  ? 8'd127 :
                      (state_q == SOP)  ? 8'd19  :
                      (state_q == DATA) ? 8'd9   :
                      (state_q == CRC)  ? 8'd39  :
                      (state_q == EOP)  ? 8'd4   : 8'(IFRGAP_BITS - 1);
    assign done     = bit_clk_red && (state_q != IDLE) && (bcnt_q == last_bit);
    assign msg      = !hrst_seq_q && !crst_seq_q;
    assign abort    = hrst_red_q && msg && (state_q == SOP || state_q == DATA || state_q == CRC);
    assign pay_m1   = tx_paysize - CNT_W'(1);
    assign byte_nxt = byte_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        byte_cnt_d    = byte_cnt_q;
        hrst_seq_d    = hrst_seq_q;
        crst_seq_d    = crst_seq_q;
        hrst_pend_d   = hrst_pend_q;
        txdr_req_d    = 1'b0;
        tx_pre_cmplt  = 1'b0;
        tx_sop_cmplt  = 1'b0;
        tx_data_cmplt = 1'b0;
        tx_crc_cmplt  = 1'b0;
        tx_eop_cmplt  = 1'b0;
        tx_wait_cmplt = 1'b0;
        tx_bit5_cmplt = 1'b0;
        txfifo_ld_en  = 1'b0;
        crc_byte_vld  = 1'b0;
        crc_init      = 1'b0;
        tx_msg_disc   = 1'b0;
        tx_hrst_disc  = 1'b0;
        if (state_q != IDLE && bit_clk_red)
            bcnt_d = bcnt_q + 8'd1;
        if (abort) begin
            state_d    = EOP;
            hrst_seq_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hrst_red_q) begin
                        tx_hrst_disc = rx_busy;
                        hrst_seq_d   = !rx_busy;
                        state_d      = rx_busy ? IDLE : PRE;
                    end else if (crst_red_q) begin
                        tx_msg_disc = rx_busy;
                        crst_seq_d  = !rx_busy;
                        state_d     = rx_busy ? IDLE : PRE;
                    end else if (xmit_red_q) begin
                        tx_msg_disc = rx_busy;
                        state_d     = rx_busy ? IDLE : PRE;
                    end
                end
                PRE: begin
                    if (done) begin
                        tx_pre_cmplt = 1'b1;
                        crc_init     = msg;
                        state_d      = SOP;
                    end
                end
                SOP: begin
                    tx_bit5_cmplt = bit_clk_red && (bcnt_q == 8'd4 || bcnt_q == 8'd9 ||
                                                    bcnt_q == 8'd14 || bcnt_q == 8'd19);
                    if (done) begin
                        tx_sop_cmplt  = 1'b1;
                        tx_data_cmplt = msg && tx_paysize == '0;
                        txfifo_ld_en  = msg && tx_paysize != '0;
                        crc_byte_vld  = msg && tx_paysize != '0;
                        state_d       = !msg ? WAIT : (tx_paysize == '0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    if (done && byte_cnt_q == pay_m1) begin
                        tx_data_cmplt = 1'b1;
                        state_d       = CRC;
                    end else if (done) begin
                        txfifo_ld_en = 1'b1;
                        crc_byte_vld = 1'b1;
                        byte_cnt_d   = byte_nxt;
                        txdr_req_d   = byte_nxt < pay_m1;
                        bcnt_d       = 8'd0;
                    end
                end
                CRC: begin
                    tx_crc_cmplt = done;
                    state_d      = done ? EOP : CRC;
                end
                EOP: begin
                    tx_eop_cmplt = done;
                    state_d      = !done ? EOP : hrst_seq_q ? PRE : WAIT;
                end
                WAIT: begin
                    if (done) begin
                        tx_wait_cmplt = 1'b1;
                        hrst_seq_d    = hrst_pend_q || hrst_red_q;
                        crst_seq_d    = 1'b0;
                        hrst_pend_d   = 1'b0;
                        state_d       = (hrst_pend_q || hrst_red_q) ? PRE : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // a hard reset that cannot abort the running message is replayed after its WAIT
            if (hrst_red_q && msg && !done && (state_q == PRE || state_q == EOP || state_q == WAIT))
                hrst_pend_d = 1'b1;
        end
        if (state_d != state_q)
            bcnt_d = 8'd0;
        if (state_d != DATA)
            byte_cnt_d = '0;
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q       <= IDLE;
            bcnt_q        <= 8'd0;
            byte_cnt_q    <= '0;
            hrst_seq_q    <= 1'b0;
            crst_seq_q    <= 1'b0;
            hrst_pend_q   <= 1'b0;
            transmit_en_q <= 1'b0;
            tx_hrst_q     <= 1'b0;
            crst_lvl_q    <= 1'b0;
            xmit_red_q    <= 1'b0;
            hrst_red_q    <= 1'b0;
            crst_red_q    <= 1'b0;
            txdr_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            byte_cnt_q    <= byte_cnt_d;
            hrst_seq_q    <= hrst_seq_d;
            crst_seq_q    <= crst_seq_d;
            hrst_pend_q   <= hrst_pend_d;
            transmit_en_q <= transmit_en;
            tx_hrst_q     <= tx_hrst;
            crst_lvl_q    <= crst_lvl;
            xmit_red_q    <= xmit_red_d;
            hrst_red_q    <= hrst_red_d;
            crst_red_q    <= crst_red_d;
            txdr_req_q    <= txdr_req_d;
        end
    end
endmodule

// File: tb/tb_apb_ucpd_tx_fsm.sv
// tb_apb_ucpd_tx_fsm: directed self-checking bench for the UCPD transmit sequencer.
module tb_apb_ucpd_tx_fsm;
    localparam int CNT_W = 10;
    localparam int NC = 24;
    localparam int I_P = 0, I_S = 1, I_D = 2, I_C = 3, I_E = 4, I_PC = 5, I_DC = 6;
    localparam int I_PREC = 7, I_SOPC = 8, I_DATAC = 9, I_CRCC = 10, I_EOPC = 11, I_WAITC = 12;
    localparam int I_BIT5 = 13, I_LD = 14, I_TXDR = 15, I_INIT = 16, I_VLD = 17;
    localparam int I_MDISC = 18, I_HDISC = 19, I_SD = 20, I_S2C = 21, I_OVL = 22, I_WIDE = 23;

    logic             ic_clk = 1'b0, ic_rst_n = 1'b0, bit_clk_red = 1'b0;
    logic             transmit_en = 1'b0, tx_hrst = 1'b0, rx_busy = 1'b0;
    logic [1:0]       tx_mode = 2'b00;
    logic [CNT_W-1:0] tx_paysize = '0;
    logic pre_en, sop_en, data_en, crc_en, eop_en;
    logic tx_pre_cmplt, tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt, tx_bit5_cmplt;
    logic txfifo_ld_en, txdr_req, crc_init, crc_byte_vld, tx_msg_disc, tx_hrst_disc;

    int c[NC];
    int b[NC];
    int b2[NC];
    int gap = 0, last_gap = 0, div = 0;
    int nvec = 0, nfail = 0;
    logic [4:0]  en;
    logic [12:0] st, st_prev = '0;
    logic        sop_prev = 1'b0;

    apb_ucpd_tx_fsm #(.IFRGAP_BITS(25), .CNT_W(CNT_W)) dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .bit_clk_red(bit_clk_red),
        .transmit_en(transmit_en), .tx_hrst(tx_hrst), .tx_mode(tx_mode),
        .tx_paysize(tx_paysize), .rx_busy(rx_busy),
        .pre_en(pre_en), .sop_en(sop_en), .data_en(data_en), .crc_en(crc_en), .eop_en(eop_en),
        .tx_pre_cmplt(tx_pre_cmplt), .tx_sop_cmplt(tx_sop_cmplt), .tx_data_cmplt(tx_data_cmplt),
        .tx_crc_cmplt(tx_crc_cmplt), .tx_eop_cmplt(tx_eop_cmplt), .tx_wait_cmplt(tx_wait_cmplt),
        .tx_bit5_cmplt(tx_bit5_cmplt), .txfifo_ld_en(txfifo_ld_en), .txdr_req(txdr_req),
        .crc_init(crc_init), .crc_byte_vld(crc_byte_vld), .tx_msg_disc(tx_msg_disc),
        .tx_hrst_disc(tx_hrst_disc)
    );

    assign en = {pre_en, sop_en, data_en, crc_en, eop_en};
    assign st = {tx_pre_cmplt, tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
                 tx_bit5_cmplt, txfifo_ld_en, txdr_req, crc_init, crc_byte_vld, tx_msg_disc, tx_hrst_disc};

    always #5 ic_clk = ~ic_clk;

    initial begin
        forever begin
            @(posedge ic_clk);
            #1;
            div = (div + 1) % 4;
            bit_clk_red = (div == 0);
        end
    end

    initial for (int i = 0; i < NC; i++) c[i] = 0;

    always @(negedge ic_clk) begin
        if (ic_rst_n) begin
            for (int i = 0; i < 5; i++) c[i] += int'(en[4-i] & bit_clk_red);
            c[I_PC] += int'(pre_en);
            c[I_DC] += int'(data_en);
            for (int j = 0; j < 13; j++) c[I_PREC+j] += int'(st[12-j]);
            c[I_SD]   += int'(tx_sop_cmplt & tx_data_cmplt);
            c[I_S2C]  += int'(sop_prev & crc_en);
            c[I_OVL]  += int'($countones(en) > 1);
            c[I_WIDE] += $countones(st & st_prev);
            if (|en) gap = 0;
            else if (bit_clk_red) gap++;
            if (tx_wait_cmplt) last_gap = gap;
            sop_prev = sop_en;
            st_prev  = st;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input int idx, input int exp);
        chk(tag, c[idx] - b[idx], exp);
    endtask

    task automatic run_wait(input string tag);
        int start = c[I_WAITC];
        int k = 0;
        while (c[I_WAITC] == start && k < 4000) begin
            @(negedge ic_clk);
            k++;
        end
        chk({tag, "_done"}, int'(c[I_WAITC] != start), 1);
        repeat (4) @(negedge ic_clk);
    endtask

    task automatic kick_msg(input string tag);
        logic p0, p1;
        @(posedge ic_clk);
        #1 transmit_en = 1'b1;
        @(negedge ic_clk);
        @(negedge ic_clk);
        p0 = pre_en;
        @(negedge ic_clk);
        p1 = pre_en;
        chk({tag, "_lat1"}, int'(p0), 0);
        chk({tag, "_lat2"}, int'(p1), 1);
    endtask

    task automatic drop_all();
        @(posedge ic_clk);
        #1;
        transmit_en = 1'b0;
        tx_hrst = 1'b0;
        tx_mode = 2'b00;
        rx_busy = 1'b0;
        repeat (3) @(posedge ic_clk);
    endtask

    initial begin
        repeat (3) @(posedge ic_clk);
        chk("reset_outs", int'({en, st}), 0);
        #1 ic_rst_n = 1'b1;
        repeat (2) @(posedge ic_clk);

        // message with two payload bytes
        tx_paysize = 10'd2;
        b = c;
        kick_msg("m2");
        run_wait("m2");
        chkd("m2_pre", I_P, 128);
        chkd("m2_sop", I_S, 20);
        chkd("m2_data", I_D, 20);
        chkd("m2_crc", I_C, 40);
        chkd("m2_eop", I_E, 5);
        chk("m2_wait", last_gap, 25);
        chkd("m2_ld", I_LD, 2);
        chkd("m2_vld", I_VLD, 2);
        chkd("m2_txdr", I_TXDR, 0);
        chkd("m2_waitc", I_WAITC, 1);
        chkd("m2_init", I_INIT, 1);
        chkd("m2_datac", I_DATAC, 1);
        chkd("m2_bit5", I_BIT5, 4);
        chkd("m2_s2c", I_S2C, 0);
        chk("m2_idle", int'(en), 0);
        drop_all();

        // empty payload goes straight from SOP to CRC
        tx_paysize = 10'd0;
        b = c;
        kick_msg("m0");
        run_wait("m0");
        chkd("m0_sd", I_SD, 1);
        chkd("m0_datacyc", I_DC, 0);
        chkd("m0_s2c", I_S2C, 1);
        chkd("m0_crc", I_C, 40);
        chkd("m0_ld", I_LD, 0);
        drop_all();

        // send request while receiver busy is discarded
        b = c;
        @(posedge ic_clk);
        #1 rx_busy = 1'b1;
        transmit_en = 1'b1;
        repeat (40) @(negedge ic_clk);
        chkd("busy_disc", I_MDISC, 1);
        chkd("busy_precyc", I_PC, 0);
        chk("busy_idle", int'(en), 0);
        drop_all();

        // hard reset with receiver busy is discarded
        b = c;
        @(posedge ic_clk);
        #1 rx_busy = 1'b1;
        tx_hrst = 1'b1;
        repeat (40) @(negedge ic_clk);
        chkd("hbusy_disc", I_HDISC, 1);
        chkd("hbusy_precyc", I_PC, 0);
        drop_all();

        // hard reset aborting DATA byte 1 bit 3
        tx_paysize = 10'd3;
        b = c;
        kick_msg("ab");
        begin
            int k = 0;
            while (c[I_D] - b[I_D] < 13 && k < 4000) begin
                @(negedge ic_clk);
                k++;
            end
        end
        @(posedge ic_clk);
        #1 tx_hrst = 1'b1;
        b2 = c;
        run_wait("ab");
        chkd("ab_data", I_D, 13);
        chkd("ab_ld", I_LD, 2);
        chkd("ab_txdr", I_TXDR, 1);
        chkd("ab_crc", I_C, 0);
        chkd("ab_init", I_INIT, 1);
        chkd("ab_waitc", I_WAITC, 1);
        b = b2;
        chkd("ab_eop", I_E, 5);
        chkd("ab_pre", I_P, 128);
        chkd("ab_sop", I_S, 20);
        chkd("ab_bit5", I_BIT5, 4);
        chkd("ab_data2", I_D, 0);
        chk("ab_wait", last_gap, 25);
        drop_all();

        // simultaneous hard reset and send request
        tx_paysize = 10'd2;
        b = c;
        @(posedge ic_clk);
        #1 tx_hrst = 1'b1;
        transmit_en = 1'b1;
        run_wait("hx");
        chkd("hx_pre", I_P, 128);
        chkd("hx_sop", I_S, 20);
        chkd("hx_data", I_DC, 0);
        chkd("hx_eop", I_E, 0);
        chkd("hx_mdisc", I_MDISC, 0);
        chkd("hx_init", I_INIT, 0);
        chk("hx_wait", last_gap, 25);
        drop_all();

        // cable reset
        b = c;
        @(posedge ic_clk);
        #1 tx_mode = 2'b01;
        run_wait("cr");
        chkd("cr_pre", I_P, 128);
        chkd("cr_sop", I_S, 20);
        chkd("cr_data", I_DC, 0);
        chkd("cr_crc", I_C, 0);
        drop_all();

        // asynchronous reset mid-CRC, then a clean restart
        tx_paysize = 10'd0;
        b = c;
        kick_msg("rs");
        begin
            int k = 0;
            while (c[I_C] - b[I_C] < 10 && k < 4000) begin
                @(negedge ic_clk);
                k++;
            end
        end
        #1 ic_rst_n = 1'b0;
        transmit_en = 1'b0;
        #1 chk("rs_outs", int'({en, st}), 0);
        repeat (2) @(posedge ic_clk);
        #1 ic_rst_n = 1'b1;
        repeat (2) @(posedge ic_clk);
        b = c;
        kick_msg("rs2");
        run_wait("rs2");
        chkd("rs2_pre", I_P, 128);
        chkd("rs2_crc", I_C, 40);
        drop_all();

        chk("no_overlap", c[I_OVL], 0);
        chk("strobe_width", c[I_WIDE], 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
